// File: rtl/lc3_dmem_responder.sv
// LC3 data-memory responder: services MemAccess reads, indirect reads and
// writes against a local RAM with a fixed, parameterised completion latency.
module lc3_dmem_responder #(
   parameter int    DEPTH_LOG2 = 8,
   parameter int    LATENCY    = 1,
   parameter string INIT_FILE  = ""
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] DMem_addr,
   input  logic [15:0] DMem_din,
   input  logic        DMem_rd,
   input  logic [1:0]  mem_state,
   output logic [15:0] DMem_dout,
   output logic        complete_data,
   output logic        busy,
   output logic        proto_err,
   output logic        oob_err
);

   localparam int         WORDS    = 1 << DEPTH_LOG2;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [1:0]  rst_q;
   logic        rst_i;
   logic [3:0]  cnt_q;
   logic [15:0] lat_addr;
   logic [15:0] lat_din;
   logic        lat_rd;
   logic [1:0]  lat_ms;
   logic [17:0] last_req;
   logic        rearm_q;
   logic        rd_match;
   logic        req_valid;
   logic        req_bad;
   logic        accept;
   logic        fire;
   logic [15:0] op_addr;
   logic [15:0] op_din;
   logic        op_rd;
   logic [1:0]  op_ms;
   logic        op_oob;
   logic [DEPTH_LOG2-1:0] op_idx;
   logic [15:0] ram [WORDS];

   // Reset asserts at once but releases only on a clock edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rst_q <= 2'b11;
      end else begin
         rst_q <= {rst_q[0], 1'b0};
      end
   end

   assign rst_i = rst_q[1];

   assign rd_match  = DMem_rd == (mem_state != 2'b10);
   assign req_valid = (mem_state != 2'b11) && rd_match;
   assign req_bad   = (mem_state != 2'b11) && !rd_match;
   assign accept    = (state_q == IDLE) && rearm_q && req_valid;

   // Single-cycle latency services the live request; otherwise the latched one
   always_comb begin
      op_addr = lat_addr;
      op_din  = lat_din;
      op_rd   = lat_rd;
      op_ms   = lat_ms;
      if (state_q == IDLE) begin
         op_addr = DMem_addr;
         op_din  = DMem_din;
         op_rd   = DMem_rd;
         op_ms   = mem_state;
      end
   end

   assign op_idx = op_addr[DEPTH_LOG2-1:0];
   assign op_oob = |(op_addr >> DEPTH_LOG2);

   always_comb begin
      state_d = state_q;
      fire    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_d = DONE;
                  fire    = 1'b1;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt_q == 4'd1) begin
               state_d = DONE;
               fire    = 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         lat_addr      <= '0;
         lat_din       <= '0;
         lat_rd        <= 1'b0;
         lat_ms        <= 2'b11;
         last_req      <= '0;
         rearm_q       <= 1'b1;
         DMem_dout     <= '0;
         complete_data <= 1'b0;
         busy          <= 1'b0;
         proto_err     <= 1'b0;
         oob_err       <= 1'b0;
      end else begin
         state_q       <= state_d;
         complete_data <= fire;
         oob_err       <= fire && op_oob;
         busy          <= state_d != IDLE;
         proto_err     <= (state_q == IDLE) && req_bad;
         if (accept) begin
            lat_addr <= DMem_addr;
            lat_din  <= DMem_din;
            lat_rd   <= DMem_rd;
            lat_ms   <= mem_state;
            cnt_q    <= CNT_INIT;
         end else if (state_q == BUSY) begin
            cnt_q <= cnt_q - 4'd1;
         end
         // A held request is served once; it must change or idle to rearm
         if (fire) begin
            last_req <= {op_ms, op_addr};
            rearm_q  <= 1'b0;
            if (op_rd) begin
               DMem_dout <= op_oob ? 16'h0000 : ram[op_idx];
            end
         end else if ((mem_state == 2'b11) ||
                      ({mem_state, DMem_addr} != last_req)) begin
            rearm_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (fire && !op_rd && !op_oob && !rst_i) begin
         ram[op_idx] <= op_din;
      end
   end

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Directed bench for lc3_dmem_responder at LATENCY 1 and 4 sharing stimulus.
module tb_lc3_dmem_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] addr  = '0;
   logic [15:0] din   = '0;
   logic        rd    = 1'b0;
   logic [1:0]  ms    = 2'b11;
   logic [15:0] dout1, dout4;
   logic        cd1, cd4, busy1, busy4;
   logic        pe1, pe4, oe1, oe4;
   int          checks   = 0;
   int          failures = 0;

   always #5 clock = ~clock;

   lc3_dmem_responder #(
      .DEPTH_LOG2(8),
      .LATENCY(1),
      .INIT_FILE("")
   ) u_l1 (
      .clock(clock),
      .reset(reset),
      .DMem_addr(addr),
      .DMem_din(din),
      .DMem_rd(rd),
      .mem_state(ms),
      .DMem_dout(dout1),
      .complete_data(cd1),
      .busy(busy1),
      .proto_err(pe1),
      .oob_err(oe1)
   );

   lc3_dmem_responder #(
      .DEPTH_LOG2(8),
      .LATENCY(4),
      .INIT_FILE("")
   ) u_l4 (
      .clock(clock),
      .reset(reset),
      .DMem_addr(addr),
      .DMem_din(din),
      .DMem_rd(rd),
      .mem_state(ms),
      .DMem_dout(dout4),
      .complete_data(cd4),
      .busy(busy4),
      .proto_err(pe4),
      .oob_err(oe4)
   );

   typedef struct {
      int          n;
      int          k;
      logic [15:0] q;
      logic        e;
      int          b;
      int          p;
   } res_t;

   typedef struct {
      logic [1:0]  ms;
      logic        rd;
      logic [15:0] addr;
      logic [15:0] din;
      logic [15:0] q;
      logic        e;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tally(input int k, input logic c, input logic [15:0] q,
                        input logic e, input logic b, input logic p,
                        inout res_t r);
      if (c) begin
         if (r.n == 0) begin
            r.k = k;
            r.q = q;
            r.e = e;
         end
         r.n++;
      end
      if (b) r.b++;
      if (p) r.p++;
   endtask

   task automatic run(input int cycles, output res_t r1, output res_t r4);
      r1 = '{default: 0};
      r4 = '{default: 0};
      for (int k = 1; k <= cycles; k++) begin
         @(posedge clock);
         @(negedge clock);
         tally(k, cd1, dout1, oe1, busy1, pe1, r1);
         tally(k, cd4, dout4, oe4, busy4, pe4, r4);
      end
   endtask

   task automatic idle_cycle();
      ms = 2'b11;
      rd = 1'b0;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic req(input logic [1:0] m, input logic r,
                      input logic [15:0] a, input logic [15:0] d,
                      output res_t r1, output res_t r4);
      ms   = m;
      rd   = r;
      addr = a;
      din  = d;
      run(10, r1, r4);
      idle_cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   vec_t v[13];
   res_t r1, r4;
   int   k1q[$];
   int   k4q[$];
   logic [15:0] q1q[$];
   logic [15:0] q4q[$];

   initial begin
      v[0]  = '{2'b10, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
      v[1]  = '{2'b10, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
      v[2]  = '{2'b00, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
      v[3]  = '{2'b10, 1'b0, 16'h0020, 16'h1234, 16'hBEEF, 1'b0};
      v[4]  = '{2'b00, 1'b1, 16'h0020, 16'h0000, 16'h1234, 1'b0};
      v[5]  = '{2'b10, 1'b0, 16'h0030, 16'h0040, 16'h1234, 1'b0};
      v[6]  = '{2'b10, 1'b0, 16'h0040, 16'h5555, 16'h1234, 1'b0};
      v[7]  = '{2'b10, 1'b0, 16'h0005, 16'h0ABC, 16'h1234, 1'b0};
      v[8]  = '{2'b01, 1'b1, 16'h0030, 16'h0000, 16'h0040, 1'b0};
      v[9]  = '{2'b10, 1'b0, 16'h0100, 16'hDEAD, 16'h0040, 1'b1};
      v[10] = '{2'b00, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0};
      v[11] = '{2'b00, 1'b1, 16'hFF20, 16'h0000, 16'h0000, 1'b1};
      v[12] = '{2'b00, 1'b1, 16'h0005, 16'h0000, 16'h0ABC, 1'b0};

      #2 reset = 1'b1;
      #1;
      chk("rst_out_l1", {dout1, cd1, busy1, pe1, oe1}, 32'h0);
      chk("rst_out_l4", {dout4, cd4, busy4, pe4, oe4}, 32'h0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("post_rst_l1", {dout1, cd1, busy1, pe1, oe1}, 32'h0);
      chk("post_rst_l4", {dout4, cd4, busy4, pe4, oe4}, 32'h0);

      for (int i = 0; i < 13; i++) begin
         req(v[i].ms, v[i].rd, v[i].addr, v[i].din, r1, r4);
         chk($sformatf("v%0d_n_l1", i), r1.n, 1);
         chk($sformatf("v%0d_lat_l1", i), r1.k, 1);
         chk($sformatf("v%0d_dout_l1", i), r1.q, v[i].q);
         chk($sformatf("v%0d_oob_l1", i), r1.e, v[i].e);
         chk($sformatf("v%0d_busy_l1", i), r1.b, 1);
         chk($sformatf("v%0d_n_l4", i), r4.n, 1);
         chk($sformatf("v%0d_lat_l4", i), r4.k, 4);
         chk($sformatf("v%0d_dout_l4", i), r4.q, v[i].q);
         chk($sformatf("v%0d_oob_l4", i), r4.e, v[i].e);
         chk($sformatf("v%0d_busy_l4", i), r4.b, 4);
         chk($sformatf("v%0d_perr", i), r1.p + r4.p, 0);
      end

      req(2'b00, 1'b1, 16'h0005, 16'h0000, r1, r4);
      chk("hold_n_l1", r1.n, 1);
      chk("hold_n_l4", r4.n, 1);
      req(2'b00, 1'b1, 16'h0005, 16'h0000, r1, r4);
      chk("rearm_n_l1", r1.n, 1);
      chk("rearm_n_l4", r4.n, 1);
      chk("rearm_dout_l4", r4.q, 16'h0ABC);

      ms   = 2'b01;
      rd   = 1'b1;
      addr = 16'h0030;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clock);
         @(negedge clock);
         if (cd1) begin
            k1q.push_back(k);
            q1q.push_back(dout1);
         end
         if (cd4) begin
            k4q.push_back(k);
            q4q.push_back(dout4);
         end
         if (k == 1) begin
            ms   = 2'b00;
            addr = 16'h0040;
         end
      end
      idle_cycle();
      chk("ldi_n_l1", k1q.size(), 2);
      chk("ldi_n_l4", k4q.size(), 2);
      if (k1q.size() == 2) begin
         chk("ldi_k_l1", {k1q[0][15:0], k1q[1][15:0]}, {16'd1, 16'd3});
         chk("ldi_q_l1", {q1q[0], q1q[1]}, {16'h0040, 16'h5555});
      end
      if (k4q.size() == 2) begin
         chk("ldi_k_l4", {k4q[0][15:0], k4q[1][15:0]}, {16'd4, 16'd9});
         chk("ldi_q_l4", {q4q[0], q4q[1]}, {16'h0040, 16'h5555});
      end

      ms   = 2'b10;
      rd   = 1'b1;
      addr = 16'h0000;
      @(posedge clock);
      @(negedge clock);
      chk("perr_wr_l1", {pe1, cd1, busy1}, 3'b100);
      chk("perr_wr_l4", {pe4, cd4, busy4}, 3'b100);
      ms = 2'b00;
      rd = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("perr_rd_l1", {pe1, cd1, busy1}, 3'b100);
      chk("perr_rd_l4", {pe4, cd4, busy4}, 3'b100);
      ms = 2'b11;
      run(6, r1, r4);
      chk("perr_quiet", r1.n + r4.n + r1.p + r4.p + r1.b + r4.b, 0);

      req(2'b10, 1'b0, 16'h0011, 16'h7777, r1, r4);
      req(2'b00, 1'b1, 16'h0011, 16'h0000, r1, r4);
      chk("pre_rst_l1", r1.q, 16'h7777);
      chk("pre_rst_l4", r4.q, 16'h7777);
      ms   = 2'b10;
      rd   = 1'b0;
      addr = 16'h0011;
      din  = 16'hAAAA;
      repeat (2) begin
         @(posedge clock);
         @(negedge clock);
      end
      chk("mid_wr_busy_l4", {busy4, cd4}, 2'b10);
      reset = 1'b1;
      #1;
      chk("mid_rst_l1", {dout1, cd1, busy1, pe1, oe1}, 32'h0);
      chk("mid_rst_l4", {dout4, cd4, busy4, pe4, oe4}, 32'h0);
      ms = 2'b11;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      req(2'b00, 1'b1, 16'h0011, 16'h0000, r1, r4);
      chk("abort_n_l4", r4.n, 1);
      chk("abort_lat_l4", r4.k, 4);
      chk("abort_q_l4", r4.q, 16'h7777);
      chk("commit_q_l1", r1.q, 16'hAAAA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
